poly_tone_gen: RTL and testbench

Parametrised polyphonic square-wave tone generator for the music board's 100 MHz clock domain. It accepts note commands (channel, semitone, octave, duration in ms) over a valid/ready interface and runs up to NUM_CH independent tone channels, each with its own half-period divider and duration timer. All channels are mixed into the single-bit speaker pin by a first-order sigma-delta modulator. It sits between the keyboard/sequencer logic and the speaker output.

---
 rtl/tone_pkg.sv | 33 +++
 rtl/tone_channel.sv | 67 ++++++
 rtl/poly_tone_gen.sv | 91 +++++++++
 tb/tb_poly_tone_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and the note tables for the polyphonic tone generator.
package tone_pkg;

  localparam int unsigned DIV_W = 18;

  typedef enum logic {IDLE, PLAY} ch_state_t;

  // Half-period in clocks at 100 MHz for octave 0 (C4..B4).
  function automatic logic [DIV_W-1:0] base_half(input logic [3:0] semi);
    logic [DIV_W-1:0] h;
    case (semi)
      4'd0:    h = 18'd191110;
      4'd1:    h = 18'd180388;
      4'd2:    h = 18'd170265;
      4'd3:    h = 18'd160705;
      4'd4:    h = 18'd151685;
      4'd5:    h = 18'd143172;
      4'd6:    h = 18'd135139;
      4'd7:    h = 18'd127551;
      4'd8:    h = 18'd120395;
      4'd9:    h = 18'd113636;
      4'd10:   h = 18'd107259;
      4'd11:   h = 18'd101238;
      default: h = '0;
    endcase
    return h;
  endfunction

  function automatic logic is_rest(input logic [3:0] semi);
    return semi >= 4'd12;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: square-wave divider plus a ms duration timer.
module tone_channel
  import tone_pkg::*;
#(
  parameter int unsigned DUR_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             rest,
  input  logic [DIV_W-1:0] half,
  input  logic [DUR_W-1:0] dur,
  input  logic             tick,
  output logic             active,
  output logic             square,
  output logic             done
);

  ch_state_t        state;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] half_q;
  logic [DUR_W-1:0] ms;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      half_q <= '0;
      ms     <= '0;
      square <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // A load masks any tick this cycle, so a new duration starts undecremented.
        count  <= '0;
        square <= 1'b0;
        if (rest) begin
          state <= IDLE;
        end else begin
          state  <= PLAY;
          half_q <= half;
          ms     <= dur;
        end
      end else if (state == PLAY) begin
        if (count == half_q - 1'b1) begin
          count  <= '0;
          square <= ~square;
        end else begin
          count <= count + 1'b1;
        end
        if (tick && ms != '0) begin
          ms <= ms - 1'b1;
          if (ms == DUR_W'(1)) begin
            state  <= IDLE;
            square <= 1'b0;
            count  <= '0;
            done   <= 1'b1;
          end
        end
      end
    end
  end

  assign active = (state == PLAY);

endmodule

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave generator: command decode, ms prescaler,
// per-channel tone units and a first-order sigma-delta mixer.
module poly_tone_gen
  import tone_pkg::*;
#(
  parameter  int unsigned CLK_HZ   = 100_000_000,
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned DUR_W    = 10,
  parameter  int unsigned TICK_CYC = CLK_HZ / 1000,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [CH_W-1:0]   note_ch,
  input  logic [5:0]        note_idx,
  input  logic [DUR_W-1:0]  note_dur,
  output logic [NUM_CH-1:0] ch_active,
  output logic [NUM_CH-1:0] ch_done,
  output logic              speaker
);

  localparam int unsigned PRE_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned ACC_W = $clog2(2 * NUM_CH);

  logic [PRE_W-1:0]  pre;
  logic              tick;
  logic              accept;
  logic              ch_ok;
  logic              rest;
  logic [DIV_W-1:0]  half_eff;
  logic [NUM_CH-1:0] square;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) note_ready <= 1'b0;
    else       note_ready <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            pre <= '0;
    else if (pre == PRE_W'(TICK_CYC - 1)) pre <= '0;
    else                                  pre <= pre + 1'b1;
  end

  assign tick     = (pre == PRE_W'(TICK_CYC - 1));
  assign accept   = note_valid & note_ready;
  assign ch_ok    = (32'(note_ch) < NUM_CH);
  assign rest     = is_rest(note_idx[3:0]);
  assign half_eff = base_half(note_idx[3:0]) >> note_idx[5:4];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tone_channel #(.DUR_W(DUR_W)) u_ch (
      .clk    (clk),
      .rst    (reset),
      .load   (accept && ch_ok && (note_ch == CH_W'(i))),
      .rest   (rest),
      .half   (half_eff),
      .dur    (note_dur),
      .tick   (tick),
      .active (ch_active[i]),
      .square (square[i]),
      .done   (ch_done[i])
    );
  end

  always_comb begin
    s = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      s = s + ACC_W'(ch_active[i] & square[i]);
    end
    sum = acc + s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      speaker <= 1'b0;
    end else if (sum >= ACC_W'(NUM_CH)) begin
      acc     <= sum - ACC_W'(NUM_CH);
      speaker <= 1'b1;
    end else begin
      acc     <= sum;
      speaker <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Directed bench for poly_tone_gen with a 100-cycle ms tick.
module tb_poly_tone_gen;

  localparam int unsigned TICK = 100;
  localparam int HA = 14204;  // A7 half-period: 113636 >> 3
  localparam int HB = 12654;  // B7 half-period: 101238 >> 3

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [1:0] note_ch = '0;
  logic [5:0] note_idx = '0;
  logic [9:0] note_dur = '0;
  logic [3:0] ch_active;
  logic [3:0] ch_done;
  logic       speaker;

  logic       v3 = 1'b0;
  logic       rdy3;
  logic [1:0] ch3 = '0;
  logic [5:0] idx3 = '0;
  logic [9:0] dur3 = '0;
  logic [2:0] act3;
  logic [2:0] done3;
  logic       spk3;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt[4];
  int t, d, h, tick_edge;

  poly_tone_gen #(.NUM_CH(4), .DUR_W(10), .TICK_CYC(TICK)) u_dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
    .note_ch(note_ch), .note_idx(note_idx), .note_dur(note_dur),
    .ch_active(ch_active), .ch_done(ch_done), .speaker(speaker)
  );

  poly_tone_gen #(.NUM_CH(3), .DUR_W(10), .TICK_CYC(TICK)) u_dut3 (
    .clk(clk), .reset(reset), .note_valid(v3), .note_ready(rdy3),
    .note_ch(ch3), .note_idx(idx3), .note_dur(dur3),
    .ch_active(act3), .ch_done(done3), .speaker(spk3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) for (int i = 0; i < 4; i++) if (ch_done[i]) done_cnt[i]++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [5:0] idx, input logic [9:0] dur);
    note_ch = c; note_idx = idx; note_dur = dur; note_valid = 1'b1;
    step(1);
    note_valid = 1'b0;
  endtask

  task automatic send3(input logic [1:0] c, input logic [5:0] idx, input logic [9:0] dur);
    ch3 = c; idx3 = idx; dur3 = dur; v3 = 1'b1;
    step(1);
    v3 = 1'b0;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      step(1);
      if (speaker) hi++;
    end
  endtask

  task automatic wait_done(input int idx, input int limit);
    for (int k = 0; k < limit; k++) begin
      step(1);
      if (ch_done[idx]) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;

    // Reset state
    #23;
    chk("rst_ready", 32'(note_ready), 0);
    chk("rst_active", 32'(ch_active), 0);
    chk("rst_done", 32'(ch_done), 0);
    chk("rst_speaker", 32'(speaker), 0);
    reset = 1'b0;
    #1;
    chk("ready_before_edge", 32'(note_ready), 0);
    step(1);
    chk("ready_after_edge", 32'(note_ready), 1);

    // Single A7 note: first toggle timing and 25% duty while square is high
    send(2'd0, 6'h39, 10'd0);
    t = cyc;
    chk("a7_active", 32'(ch_active), 32'h1);
    count_high(HA + 3, h);
    chk("a7_quiet_before_toggle", h, 0);
    step(1);
    chk("a7_first_high", 32'(speaker), 1);
    count_high(HA - 4, h);
    chk("a7_duty_high_half", h + 1, HA / 4);

    // REST while playing
    send(2'd0, 6'h0F, 10'd0);
    chk("rest_inactive", 32'(ch_active[0]), 0);
    chk("rest_no_done", done_cnt[0], 0);

    // Duration 3 ms on C6
    send(2'd1, 6'h20, 10'd3);
    t = cyc;
    chk("dur_active", 32'(ch_active), 32'h2);
    wait_done(1, 400);
    d = cyc - t;
    chk("dur_window", 32'(d >= 201 && d <= 300), 1);
    chk("dur_active_falls", 32'(ch_active[1]), 0);
    tick_edge = cyc;
    step(1);
    chk("dur_done_one_cycle", 32'(ch_done), 0);
    step(50);
    chk("dur_done_once", done_cnt[1], 1);

    // Retrigger: second duration governs, first produces no done
    send(2'd2, 6'h39, 10'd5);
    step(150);
    send(2'd2, 6'h39, 10'd2);
    t = cyc;
    wait_done(2, 300);
    d = cyc - t;
    chk("retrig_window", 32'(d >= 101 && d <= 200), 1);
    step(10);
    chk("retrig_done_once", done_cnt[2], 1);

    // Retrigger restarts the divider from zero
    send(2'd3, 6'h39, 10'd0);
    step(1000);
    send(2'd3, 6'h39, 10'd0);
    count_high(HA, h);
    chk("restart_quiet", h, 0);
    count_high(4, h);
    chk("restart_first_high", h, 1);
    send(2'd3, 6'h0F, 10'd0);
    chk("restart_rest", 32'(ch_active), 0);

    // Out-of-range channel on a 3-channel instance is dropped
    send3(2'd2, 6'h39, 10'd0);
    chk("inv_setup", 32'(act3), 32'h4);
    send3(2'd3, 6'h39, 10'd0);
    chk("inv_play_dropped", 32'(act3), 32'h4);
    chk("inv_ready", 32'(rdy3), 1);
    send3(2'd3, 6'h0F, 10'd0);
    chk("inv_rest_dropped", 32'(act3), 32'h4);
    send3(2'd2, 6'h0F, 10'd0);
    chk("inv_quiet_speaker", 32'(spk3), 0);
    chk("inv_no_done", 32'(done3), 0);

    // Four channels on B7, issued on consecutive cycles
    send(2'd0, 6'h3B, 10'd0);
    t = cyc;
    send(2'd1, 6'h3B, 10'd0);
    send(2'd2, 6'h3B, 10'd0);
    send(2'd3, 6'h3B, 10'd0);
    chk("quad_active", 32'(ch_active), 32'hF);
    count_high(HB - 3, h);
    chk("quad_all_low", h, 0);
    step(3);
    count_high(HB - 3, h);
    chk("quad_all_high", h, HB - 3);
    step(3);
    count_high(100, h);
    chk("quad_all_low_again", h, 0);
    for (int i = 0; i < 4; i++) send(2'(i), 6'h0C, 10'd0);
    chk("quad_rest", 32'(ch_active), 0);

    // Accept coinciding with a tick keeps the new duration intact
    for (int k = 0; k < 100 && ((cyc + 1 - tick_edge) % TICK) != 0; k++) step(1);
    send(2'd1, 6'h39, 10'd1);
    t = cyc;
    wait_done(1, 300);
    chk("tick_accept_latency", cyc - t, TICK);

    // Reset asserted mid-note
    send(2'd0, 6'h39, 10'd0);
    step(5);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(note_ready), 0);
    chk("midrst_active", 32'(ch_active), 0);
    chk("midrst_done", 32'(ch_done), 0);
    chk("midrst_speaker", 32'(speaker), 0);
    #14 reset = 1'b0;
    #1;
    chk("midrst_ready_held", 32'(note_ready), 0);
    step(1);
    chk("midrst_ready_rises", 32'(note_ready), 1);
    chk("midrst_still_idle", 32'(ch_active), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
